// File: rtl/mult_pkg.sv
// Shared types and default sizing for the iterative multiplier.
package mult_pkg;

  localparam int MULT_WIDTH_DEF = 32;
  localparam int MULT_RADIX_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FIXUP = 2'd2
  } mult_state_e;

endpackage

// File: rtl/mult_digit_pp.sv
// One-digit partial product: digit x multiplicand, truncated to 2*WIDTH bits.
module mult_digit_pp
  import mult_pkg::*;
#(
  parameter int WIDTH      = MULT_WIDTH_DEF,
  parameter int RADIX_BITS = MULT_RADIX_DEF
) (
  input  logic [RADIX_BITS-1:0] digit,
  input  logic [2*WIDTH-1:0]    mcand,
  output logic [2*WIDTH-1:0]    pp
);

  // Shift-and-add over the digit bits; at most four terms.
  always_comb begin
    pp = '0;
    for (int i = 0; i < RADIX_BITS; i++)
      if (digit[i]) pp = pp + (mcand << i);
  end

endmodule

// File: rtl/iter_multiplier.sv
// Iterative signed/unsigned multiply-accumulate, RADIX_BITS multiplier bits per cycle.
// Sign handling is done on magnitudes; the product is negated in FIXUP.
// Optional macro MULT_EARLY_TERM_EN: leave RUN as soon as the remaining
// multiplier is zero instead of always running WIDTH/RADIX_BITS cycles.
module iter_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH      = MULT_WIDTH_DEF,
  parameter int RADIX_BITS = MULT_RADIX_DEF
) (
  input  logic               clk,
  input  logic               Nrst,
  input  logic               start,
  input  logic               abort,
  input  logic               is_signed,
  input  logic               accumulate,
  input  logic [WIDTH-1:0]   in0,
  input  logic [WIDTH-1:0]   in1,
  input  logic [2*WIDTH-1:0] acc_in,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result
);

  localparam int NDIG = WIDTH / RADIX_BITS;
  localparam int CW   = $clog2(NDIG + 1);
  localparam int PW   = 2 * WIDTH;

  if (!(RADIX_BITS == 1 || RADIX_BITS == 2 || RADIX_BITS == 4) ||
      (WIDTH % RADIX_BITS) != 0) begin : g_param_chk
    $fatal(1, "iter_multiplier: illegal WIDTH/RADIX_BITS combination");
  end

  mult_state_e      state, state_nxt;
  logic [WIDTH-1:0] mplier, mplier_sh, mag0, mag1;
  logic [PW-1:0]    mcand, sum, acc_q, pp;
  logic [CW-1:0]    cnt;
  logic             sign_q, accum_q;
  logic             accept, step, fix, run_last;

  assign mag0      = (is_signed && in0[WIDTH-1]) ? -in0 : in0;
  assign mag1      = (is_signed && in1[WIDTH-1]) ? -in1 : in1;
  assign mplier_sh = mplier >> RADIX_BITS;

`ifdef MULT_EARLY_TERM_EN
  assign run_last = (cnt == CW'(1)) || (mplier_sh == '0);
`else
  assign run_last = (cnt == CW'(1));
`endif

  mult_digit_pp #(
    .WIDTH      (WIDTH),
    .RADIX_BITS (RADIX_BITS)
  ) u_pp (
    .digit (mplier[RADIX_BITS-1:0]),
    .mcand (mcand),
    .pp    (pp)
  );

  // State register.
  always_ff @(posedge clk or negedge Nrst) begin
    if (!Nrst) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state: abort wins over both start and FIXUP.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (start && !abort) state_nxt = ST_RUN;
      ST_RUN:   if (abort) state_nxt = ST_IDLE;
                else if (run_last) state_nxt = ST_FIXUP;
      ST_FIXUP: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Per-state control strobes.
  always_comb begin
    busy   = (state != ST_IDLE);
    accept = (state == ST_IDLE)  && start && !abort;
    step   = (state == ST_RUN)   && !abort;
    fix    = (state == ST_FIXUP) && !abort;
  end

  // Operand capture at acceptance, then one digit retired per RUN cycle.
  always_ff @(posedge clk or negedge Nrst) begin
    if (!Nrst) begin
      mplier  <= '0;
      mcand   <= '0;
      sum     <= '0;
      acc_q   <= '0;
      cnt     <= '0;
      sign_q  <= 1'b0;
      accum_q <= 1'b0;
    end else if (accept) begin
      mplier  <= mag0;
      mcand   <= {{WIDTH{1'b0}}, mag1};
      sum     <= '0;
      acc_q   <= acc_in;
      cnt     <= CW'(NDIG);
      sign_q  <= is_signed && (in0[WIDTH-1] ^ in1[WIDTH-1]);
      accum_q <= accumulate;
    end else if (step) begin
      sum    <= sum + pp;
      mplier <= mplier_sh;
      mcand  <= mcand << RADIX_BITS;
      cnt    <= cnt - CW'(1);
    end
  end

  // Sign fix-up and accumulate; result holds until the next FIXUP.
  always_ff @(posedge clk or negedge Nrst) begin
    if (!Nrst) begin
      done   <= 1'b0;
      result <= '0;
    end else begin
      done <= fix;
      if (fix) result <= (sign_q ? -sum : sum) + (accum_q ? acc_q : '0);
    end
  end

endmodule

// File: tb/tb_iter_multiplier.sv
// Bench for iter_multiplier: reference model + per-cycle compare, directed literals,
// and a small width/radix sweep on two extra instances.
module tb_iter_multiplier;

  logic        clk = 1'b0;
  logic        Nrst = 1'b0;
  logic        start = 1'b0, abort = 1'b0, is_signed = 1'b0, accumulate = 1'b0;
  logic [31:0] in0 = '0, in1 = '0;
  logic [63:0] acc_in = '0;
  logic        busy, done;
  logic [63:0] result;

  logic        s_start = 1'b0, s_sg = 1'b0;
  logic [15:0] s_a = '0, s_b = '0;
  logic        b8, d8, b16, d16;
  logic [15:0] r8;
  logic [31:0] r16;

  int n_chk = 0, n_err = 0;
  int cyc = 0, t_acc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  iter_multiplier dut (
    .clk(clk), .Nrst(Nrst), .start(start), .abort(abort), .is_signed(is_signed),
    .accumulate(accumulate), .in0(in0), .in1(in1), .acc_in(acc_in),
    .busy(busy), .done(done), .result(result));

  iter_multiplier #(.WIDTH(8), .RADIX_BITS(1)) u_w8 (
    .clk(clk), .Nrst(Nrst), .start(s_start), .abort(1'b0), .is_signed(s_sg),
    .accumulate(1'b0), .in0(s_a[7:0]), .in1(s_b[7:0]), .acc_in(16'h0),
    .busy(b8), .done(d8), .result(r8));

  iter_multiplier #(.WIDTH(16), .RADIX_BITS(4)) u_w16 (
    .clk(clk), .Nrst(Nrst), .start(s_start), .abort(1'b0), .is_signed(s_sg),
    .accumulate(1'b0), .in0(s_a), .in1(s_b), .acc_in(32'h0),
    .busy(b16), .done(d16), .result(r16));

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic on sign- or zero-extended operands.
  function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b,
                                           input logic sg, input logic ac, input logic [63:0] acc);
    logic [63:0] ea, eb;
    ea = sg ? {{32{a[31]}}, a} : {32'h0, a};
    eb = sg ? {{32{b[31]}}, b} : {32'h0, b};
    return ea * eb + (ac ? acc : 64'h0);
  endfunction

  function automatic logic [31:0] ref_n(input logic [15:0] a, input logic [15:0] b,
                                        input int w, input logic sg);
    longint ea, eb, p;
    logic [31:0] mask;
    ea = longint'(a) & ((longint'(1) << w) - 1);
    eb = longint'(b) & ((longint'(1) << w) - 1);
    if (sg && a[w-1]) ea = ea - (longint'(1) << w);
    if (sg && b[w-1]) eb = eb - (longint'(1) << w);
    p = ea * eb;
    mask = (w == 16) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    return 32'(p) & mask;
  endfunction

  // Start-to-done latency for the 32-bit instance.
  function automatic int exp_lat(input logic [31:0] a, input logic sg);
    logic [31:0] m;
    int k, lat;
    m = (sg && a[31]) ? -a : a;
    k = 0;
    for (int d = 0; d < 16; d++) if ((m >> (2 * d)) != 0) k = d + 1;
    lat = ((k < 1) ? 1 : k) + 1;
`ifndef MULT_EARLY_TERM_EN
    lat = 17;
`endif
    return lat;
  endfunction

  // Transaction-level model of the default instance.
  logic        m_busy, m_done;
  logic [63:0] m_res, m_pend;
  int          m_left;
  always @(posedge clk or negedge Nrst) begin
    if (!Nrst) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_res <= '0; m_pend <= '0; m_left <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        if (abort) m_busy <= 1'b0;
        else if (m_left == 1) begin
          m_busy <= 1'b0; m_done <= 1'b1; m_res <= m_pend;
        end else m_left <= m_left - 1;
      end else if (start && !abort) begin
        m_busy <= 1'b1;
        m_pend <= ref_prod(in0, in1, is_signed, accumulate, acc_in);
        m_left <= exp_lat(in0, is_signed);
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (Nrst) begin
      check("busy", 64'(busy), 64'(m_busy));
      check("done", 64'(done), 64'(m_done));
      check("result", result, m_res);
    end
  end

  task automatic go(input logic [31:0] a, input logic [31:0] b, input logic sg,
                    input logic ac, input logic [63:0] ai);
    in0 = a; in1 = b; is_signed = sg; accumulate = ac; acc_in = ai; start = 1'b1;
    @(posedge clk); #1;
    t_acc = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm, output int lat);
    logic ok;
    ok = 1'b0; lat = -1;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(posedge clk); #1;
      if (done) begin ok = 1'b1; lat = cyc - t_acc; end
    end
    if (!ok) begin
      n_chk++; n_err++;
      $display("FAIL %s: done not seen within 60 cycles", nm);
    end
  endtask

  int lat, lat2, t_done;
  logic got8, got16;

  initial begin
    #2;
    check("reset busy", 64'(busy), 64'h0);
    check("reset done", 64'(done), 64'h0);
    check("reset result", result, 64'h0);
    #20 Nrst = 1'b1;
    @(posedge clk); #1;

    go(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 64'h0);
    wait_done("umax", lat);
    check("umax result", result, 64'hFFFF_FFFE_0000_0001);
    check("umax latency", 64'(lat), 64'd17);

    go(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 64'h0);
    wait_done("smin", lat);
    check("smin x -1 result", result, 64'h0000_0000_8000_0000);
    check("smin latency", 64'(lat), 64'd17);

    go(32'hFFFF_FFFD, 32'd7, 1'b1, 1'b1, 64'd100);
    wait_done("mac", lat);
    check("-3x7+100 result", result, 64'd79);
`ifdef MULT_EARLY_TERM_EN
    check("-3x7 latency", 64'(lat), 64'd2);
`else
    check("-3x7 latency", 64'(lat), 64'd17);
`endif

    go(32'h0, 32'h1234, 1'b0, 1'b0, 64'h0);
    wait_done("zero", lat);
    check("0 x n result", result, 64'h0);
`ifdef MULT_EARLY_TERM_EN
    check("zero latency", 64'(lat), 64'd2);
`else
    check("zero latency", 64'(lat), 64'd17);
`endif

    go(32'h5, 32'h1000, 1'b0, 1'b0, 64'h0);
    wait_done("five", lat);
    check("5 x 0x1000 result", result, 64'h5000);
`ifdef MULT_EARLY_TERM_EN
    check("five latency", 64'(lat), 64'd3);
`else
    check("five latency", 64'(lat), 64'd17);
`endif

    go(32'd7, 32'hFFFF_FFFE, 1'b1, 1'b0, 64'h0);
    wait_done("7x-2", lat);
    check("7 x -2 result", result, 64'hFFFF_FFFF_FFFF_FFF2);

    go(32'h1_0000, 32'h1_0000, 1'b0, 1'b0, 64'h0);
    wait_done("2^16sq", lat);
    check("2^16 squared", result, 64'h1_0000_0000);

    go(32'd3, 32'd4, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    wait_done("wrap", lat);
    check("acc wraps mod 2^64", result, 64'd11);

    go(32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0, 64'h0);
    wait_done("mixed", lat);

    // Abort mid-RUN: no done, busy drops on the next edge, result held.
    go(32'hFFFF_FFFF, 32'h2, 1'b0, 1'b0, 64'h0);
    repeat (4) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort busy", 64'(busy), 64'h0);
    repeat (20) @(posedge clk);
    #1 check("abort keeps result", result, 64'hF0EE_E4A4_A358_1080 * 0 + ref_prod(32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0, 64'h0));

    // A second start while busy must be ignored.
    go(32'hFFFF_FFFF, 32'd3, 1'b0, 1'b0, 64'h0);
    repeat (3) @(posedge clk);
    #1 in0 = 32'd9; in1 = 32'd9; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done("busy start", lat);
    check("start while busy ignored", result, 64'h2_FFFF_FFFD);
    check("busy start latency", 64'(lat), 64'd17);

    // Back-to-back: start in the done cycle.
    go(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 64'h0);
    wait_done("b2b first", lat);
    t_done = cyc;
    go(32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0, 64'h0);
    check("b2b no bubble", 64'(t_acc - t_done), 64'd1);
    wait_done("b2b second", lat2);
    check("b2b second latency", 64'(lat2), 64'd17);
    check("b2b second result", result, 64'h1_FFFF_FFFE);

    // Reset mid-RUN clears everything immediately.
    go(32'hFFFF_FFFF, 32'd5, 1'b0, 1'b0, 64'h0);
    repeat (4) @(posedge clk);
    #2 Nrst = 1'b0;
    #1;
    check("rst busy", 64'(busy), 64'h0);
    check("rst done", 64'(done), 64'h0);
    check("rst result", result, 64'h0);
    @(negedge clk); #2 Nrst = 1'b1;
    @(posedge clk); #1;
    go(32'd6, 32'd7, 1'b0, 1'b0, 64'h0);
    wait_done("post reset", lat);
    check("post reset result", result, 64'd42);

    // Width/radix sweep on the 8-bit radix-2 and 16-bit radix-16 instances.
    for (int v = 0; v < 8; v++) begin
      case (v)
        0: begin s_a = 16'hFFFF; s_b = 16'hFFFF; end
        1: begin s_a = 16'h8080; s_b = 16'h7F7F; end
        2: begin s_a = 16'h0000; s_b = 16'h1234; end
        default: begin s_a = 16'($urandom); s_b = 16'($urandom); end
      endcase
      s_sg = (v % 2 == 1);
      s_start = 1'b1;
      @(posedge clk); #1;
      s_start = 1'b0;
      t_acc = cyc;
      got8 = 1'b0; got16 = 1'b0;
      for (int i = 0; i < 40 && !(got8 && got16); i++) begin
        @(posedge clk); #1;
        if (d8 && !got8) begin
          got8 = 1'b1;
          check("w8r1 result", 64'(r8), 64'(ref_n(s_a, s_b, 8, s_sg)));
`ifndef MULT_EARLY_TERM_EN
          check("w8r1 latency", 64'(cyc - t_acc), 64'd9);
`endif
        end
        if (d16 && !got16) begin
          got16 = 1'b1;
          check("w16r4 result", 64'(r16), 64'(ref_n(s_a, s_b, 16, s_sg)));
`ifndef MULT_EARLY_TERM_EN
          check("w16r4 latency", 64'(cyc - t_acc), 64'd5);
`endif
        end
      end
      if (!(got8 && got16)) begin
        n_chk++; n_err++;
        $display("FAIL sweep %0d: done not seen (w8=%0b w16=%0b)", v, got8, got16);
      end
    end

    check("ref 8b signed -128x127", 64'(ref_n(16'h0080, 16'h007F, 8, 1'b1)), 64'h0000_C080);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/iter_multiplier.md
ITER_MULTIPLIER -- requirements
Module: iter_multiplier

Interface
REQ-001 Parameters SHALL be: WIDTH, default 32, operand width; RADIX_BITS, default 2, multiplier bits retired per cycle, legal values 1, 2 or 4, WIDTH a multiple of RADIX_BITS.
REQ-002 Ports SHALL be: clk  in  1  clock; Nrst  in  1  reset, asynchronous, active-low.
REQ-003 start  in  1  request a multiply, sampled on rising clk.
REQ-004 abort  in  1  cancel an in-flight operation.
REQ-005 is_signed  in  1  two's-complement operands when 1, unsigned when 0.
REQ-006 accumulate  in  1  add acc_in to the product when 1.
REQ-007 in0  in  WIDTH  multiplier; in1  in  WIDTH  multiplicand; acc_in  in  2*WIDTH  accumulator.
REQ-008 busy  out  1  operation in flight; done  out  1  one-cycle completion pulse; result  out  2*WIDTH  product.

Function
REQ-009 States SHALL be IDLE, RUN, FIXUP; busy SHALL equal (state != IDLE).
REQ-010 start in IDLE without abort SHALL capture all inputs, take magnitudes of in0/in1 when is_signed, record sign = msb(in0) XOR msb(in1) when is_signed (else 0), clear the partial sum, enter RUN.
REQ-011 start while busy SHALL be ignored; inputs SHALL be sampled only at acceptance.
REQ-012 Each RUN cycle SHALL add (low RADIX_BITS digit of the remaining multiplier) x (shifted multiplicand) into a 2*WIDTH partial sum, shift the multiplier right and the multiplicand left by RADIX_BITS.
REQ-013 RUN SHALL exit to FIXUP after WIDTH/RADIX_BITS cycles (see REQ-022 for early exit).
REQ-014 FIXUP SHALL register result = (sign ? -sum : sum) + (accumulate ? acc_in : 0), modulo 2^(2*WIDTH), pulse done for exactly one cycle, return to IDLE.
REQ-015 Latency SHALL be WIDTH/RADIX_BITS + 1 cycles from the start edge to done visible (17 at defaults).
REQ-016 result SHALL hold its value until the next FIXUP; done SHALL be low in every other cycle.
REQ-017 start asserted in the cycle done is high SHALL be accepted (back-to-back, no bubble).
REQ-018 Most-negative operand (2^(WIDTH-1)) with is_signed SHALL yield the exact product; magnitude fits in WIDTH bits unsigned.
REQ-019 abort while busy SHALL return to IDLE on the next edge with no done pulse and result unchanged; abort SHALL take priority over start and FIXUP.

Reset
REQ-020 Nrst low SHALL immediately force state IDLE, busy 0, done 0, result 0, internal registers 0, including mid-operation; the first start after release SHALL behave as from power-up.

Configuration
REQ-021 Macro MULT_EARLY_TERM_EN SHALL select early termination.
REQ-022 With it defined, RUN SHALL exit to FIXUP on the edge whose shifted remaining multiplier is zero, giving latency max(k,1)+1 where k = count of RADIX_BITS digits up to the highest non-zero digit of |in0| (k=0 for zero); without it, latency is fixed per REQ-015.

Structure
REQ-023 A shared package mult_pkg SHALL hold the state encoding typedef and default WIDTH/RADIX_BITS constants.
REQ-024 One sub-module mult_digit_pp SHALL compute digit x multiplicand partial product (combinational, parameterised by WIDTH and RADIX_BITS); everything else stays in iter_multiplier.
REQ-025 Parameter legality (REQ-001) SHALL be checked at elaboration with a fatal error.

Verification
REQ-026 Unsigned 0xFFFFFFFF x 0xFFFFFFFF, defaults -> result 0xFFFFFFFE00000001, done 17 cycles after start (no macro).
REQ-027 Signed 0x80000000 x 0xFFFFFFFF -> result 0x0000000080000000; signed -3 x 7 with accumulate, acc_in 100 -> result 79.
REQ-028 With MULT_EARLY_TERM_EN: in0 0 -> done after 2 cycles, result 0; in0 0x5 -> done after 3 cycles, result 5*in1.
REQ-029 abort 5 cycles after start -> no done, busy low next edge, result keeps prior value; start during busy -> ignored, first result correct.
REQ-030 Nrst pulsed mid-RUN -> busy/done/result 0 at once; back-to-back start on the done cycle -> second done exactly 17 cycles later; sweep RADIX_BITS 1/2/4 with WIDTH 8/16/32 against random reference products.
